// File: rtl/addsub_pipe.sv
// addsub_pipe -- pipelined two's-complement adder/subtractor with valid/ready
// handshakes on both sides.
//
// The WIDTH-bit carry chain is cut into STAGES equal slices. Each pipeline
// stage adds one slice (LSB slice first) and registers the partial sum, the
// carry into the next slice and the operand bits that later slices still need.
// The last stage also derives the overflow flag from the MSB slice. The
// latency is STAGES cycles and the throughput is one beat per cycle.
//
// Parameters
//   WIDTH   operand/result width; must be a multiple of STAGES
//   STAGES  number of carry slices = pipeline depth, 1..WIDTH
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready     operand handshake
//   in_a, in_b              operands
//   in_sub                  1: A-B (A + ~B + 1), 0: A+B
//   in_signed               1: signed overflow rule, 0: unsigned (carry/borrow)
//   out_valid / out_ready   result handshake
//   out_sum                 result
//   out_cout                raw carry-out of the MSB slice
//   out_ovf                 overflow for this result
//   ovf_sticky              OR of out_ovf over all accepted results
//   ovf_clr                 synchronous clear of ovf_sticky (a same-cycle set wins)
//
// Build option
//   ADDSUB_SAT_EN  when defined, an overflowing result is replaced by the
//                  saturation value (out_cout stays raw); otherwise results wrap.
module addsub_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("addsub_pipe: WIDTH=%0d must be a multiple of STAGES=%0d with 1 <= STAGES <= WIDTH",
           WIDTH, STAGES);
  end

  localparam int unsigned SW   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  // One pipeline stage. b holds the already-conditioned operand (~B for sub),
  // c is the carry into the next slice. Sum bits above the slices done so far
  // are zero; operand bits below them are no longer needed and get trimmed.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             sub;
    logic             sgn;
  } stage_t;

  stage_t            st_q [STAGES];
  stage_t            st_d [STAGES];
  logic [STAGES-1:0] v_q, v_d;
  logic              ovf_q, ovf_d;
  logic              sticky_q, sticky_d;
  logic              stall;

  // Add slice k of src into the partial sum and update the carry.
  function automatic stage_t slice_add(input stage_t src, input int unsigned k);
    stage_t     r;
    logic [SW:0] part;
    r    = src;
    part = {1'b0, src.a[k*SW +: SW]} + {1'b0, src.b[k*SW +: SW]} + {{SW{1'b0}}, src.c};
    r.s[k*SW +: SW] = part[SW-1:0];
    r.c             = part[SW];
    return r;
  endfunction

  // Every stage holds on a stall, so the output register is frozen and the
  // input side is refused for exactly the cycles the sink refuses.
  assign stall    = v_q[LAST] && !out_ready;
  assign in_ready = !stall;

  always_comb begin
    stage_t           head;
    logic [WIDTH-1:0] res;
    head.a   = in_a;
    head.b   = in_sub ? ~in_b : in_b;
    head.s   = '0;
    head.c   = in_sub;
    head.sub = in_sub;
    head.sgn = in_signed;

    st_d[0] = slice_add(head, 0);
    v_d[0]  = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      st_d[k] = slice_add(st_q[k-1], k);
      v_d[k]  = v_q[k-1];
    end

    // Signed: operands (A and conditioned B) agree in sign, result does not.
    // Unsigned: carry-out on add, missing carry (borrow) on sub.
    if (st_d[LAST].sgn) begin
      ovf_d = (st_d[LAST].a[WIDTH-1] == st_d[LAST].b[WIDTH-1]) &&
              (st_d[LAST].s[WIDTH-1] != st_d[LAST].a[WIDTH-1]);
    end else begin
      ovf_d = st_d[LAST].sub ? ~st_d[LAST].c : st_d[LAST].c;
    end

`ifdef ADDSUB_SAT_EN
    res = st_d[LAST].s;
    if (ovf_d) begin
      if (st_d[LAST].sgn) begin
        // Positive overflow only happens with A >= 0, negative with A < 0.
        res            = st_d[LAST].a[WIDTH-1] ? '0 : '1;
        res[WIDTH-1]   = st_d[LAST].a[WIDTH-1];
      end else begin
        res = st_d[LAST].sub ? '0 : '1;
      end
    end
`else
    res = st_d[LAST].s;
`endif
    st_d[LAST].s = res;

    sticky_d = sticky_q;
    if (ovf_clr) sticky_d = 1'b0;
    if (v_q[LAST] && out_ready && ovf_q) sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) st_q[k] <= '0;
      v_q      <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      if (!stall) begin
        for (int unsigned k = 0; k < STAGES; k++) st_q[k] <= st_d[k];
        v_q   <= v_d;
        ovf_q <= ovf_d;
      end
      sticky_q <= sticky_d;
    end
  end

  assign out_valid  = v_q[LAST];
  assign out_sum    = st_q[LAST].s;
  assign out_cout   = st_q[LAST].c;
  assign out_ovf    = ovf_q;
  assign ovf_sticky = sticky_q;

endmodule
